// File: rtl/wfifo_write_frontend_if.sv
// Bundle of all non-clock signals around the async FIFO write front end.
// slave  : the front end itself.
// master : the surrounding environment (producer plus write-pointer handler).
interface wfifo_write_frontend_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = 3
);
   // producer stream
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;
   // write path into the pointer handler / memory
   logic                  w_en;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  full;
   // pointers and derived level
   logic [PTR_WIDTH:0]    b_wptr;
   logic [PTR_WIDTH:0]    g_rptr_sync;
   logic [PTR_WIDTH:0]    wlevel;
   logic                  almost_full;

   modport slave (
      input  s_valid, s_data, full, b_wptr, g_rptr_sync,
      output s_ready, w_en, wdata, wlevel, almost_full
   );

   modport master (
      output s_valid, s_data, full, b_wptr, g_rptr_sync,
      input  s_ready, w_en, wdata, wlevel, almost_full
   );
endinterface

// File: rtl/wfifo_write_frontend.sv
// Write-domain front end of the async FIFO: a 2-entry skid buffer between the
// producer stream and the write-pointer handler, plus a registered write-side
// fill level and almost_full flag.
module wfifo_write_frontend #(
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = 3,
   parameter int AF_THRESH  = 6
) (
   input logic                   wclk,
   input logic                   wrst_n,
   wfifo_write_frontend_if.slave bus
);

   localparam logic [PTR_WIDTH:0] AF_LEVEL = AF_THRESH[PTR_WIDTH:0];

   // output slot feeds the handler directly; skid slot absorbs one overflow word
   logic                  out_valid_reg, out_valid_next;
   logic [DATA_WIDTH-1:0] out_data_reg,  out_data_next;
   logic                  skid_valid_reg, skid_valid_next;
   logic [DATA_WIDTH-1:0] skid_data_reg,  skid_data_next;
   logic                  s_ready_reg,   s_ready_next;

   logic [PTR_WIDTH:0]    rptr_bin;
   logic [PTR_WIDTH:0]    wlevel_reg,    wlevel_next;
   logic                  almost_full_reg, almost_full_next;

   logic s_fire;
   logic consume;

   assign s_fire  = bus.s_valid & s_ready_reg;
   assign consume = out_valid_reg & ~bus.full;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   genvar gi;
   generate
      for (gi = 0; gi <= PTR_WIDTH; gi++) begin : g_gray2bin
         assign rptr_bin[gi] = ^bus.g_rptr_sync[PTR_WIDTH:gi];
      end
   endgenerate

   // Skid-buffer steering: refill the output slot oldest-first, park overflow in skid
   always_comb begin
      out_valid_next  = out_valid_reg;
      out_data_next   = out_data_reg;
      skid_valid_next = skid_valid_reg;
      skid_data_next  = skid_data_reg;

      if (consume || !out_valid_reg) begin
         if (skid_valid_reg) begin
            out_valid_next  = 1'b1;
            out_data_next   = skid_data_reg;
            skid_valid_next = s_fire;
            if (s_fire) begin
               skid_data_next = bus.s_data;
            end
         end else if (s_fire) begin
            out_valid_next = 1'b1;
            out_data_next  = bus.s_data;
         end else begin
            out_valid_next = 1'b0;
         end
      end else if (s_fire) begin
         // s_ready only stays high while the skid is empty, so it cannot be overwritten
         skid_valid_next = 1'b1;
         skid_data_next  = bus.s_data;
      end

      s_ready_next = ~skid_valid_next;
   end

   // Fill level by modulo subtraction, correct across pointer wrap
   always_comb begin
      wlevel_next      = bus.b_wptr - rptr_bin;
      almost_full_next = (wlevel_next >= AF_LEVEL);
   end

   // Buffer and handshake state; reset discards anything in flight
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
         s_ready_reg    <= 1'b0;
      end else begin
         out_valid_reg  <= out_valid_next;
         out_data_reg   <= out_data_next;
         skid_valid_reg <= skid_valid_next;
         skid_data_reg  <= skid_data_next;
         s_ready_reg    <= s_ready_next;
      end
   end

   // Registered level and almost_full (one cycle behind the pointers)
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wlevel_reg      <= '0;
         almost_full_reg <= 1'b0;
      end else begin
         wlevel_reg      <= wlevel_next;
         almost_full_reg <= almost_full_next;
      end
   end

   assign bus.s_ready     = s_ready_reg;
   assign bus.w_en        = out_valid_reg;
   assign bus.wdata       = out_data_reg;
   assign bus.wlevel      = wlevel_reg;
   assign bus.almost_full = almost_full_reg;

endmodule

// File: tb/tb_wfifo_write_frontend.sv
// Testbench for wfifo_write_frontend: directed scenarios followed by random
// traffic, checked against a queue-based model of the words in flight and an
// arithmetic model of the fill level.
module tb_wfifo_write_frontend;

   localparam int DW = 8;
   localparam int PW = 3;
   localparam int AF = 6;
   localparam int PMASK = (1 << (PW + 1)) - 1;

   logic wclk = 1'b0;
   logic wrst_n;

   always #5 wclk = ~wclk;

   wfifo_write_frontend_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

   wfifo_write_frontend #(
      .DATA_WIDTH(DW),
      .PTR_WIDTH (PW),
      .AF_THRESH (AF)
   ) dut (
      .wclk  (wclk),
      .wrst_n(wrst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // model: words accepted from the producer and not yet written, oldest first
   logic [DW-1:0] q[$];
   logic [DW-1:0] wr_log[$];
   bit            rdy_ok;
   int            exp_level;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int gray2bin(input int g);
      int b;
      b = g;
      for (int k = 1; k <= PW; k++) b = b ^ (g >> k);
      return b & PMASK;
   endfunction

   function automatic int bin2gray(input int b);
      return (b ^ (b >> 1)) & PMASK;
   endfunction

   function automatic int ref_level(input int b, input int g);
      return (b - gray2bin(g)) & PMASK;
   endfunction

   // Compare all outputs with what the model says at this point
   task automatic check_state(input string when);
      check({when, " w_en"}, bus.w_en, q.size() > 0);
      if (q.size() > 0) check({when, " wdata"}, bus.wdata, q[0]);
      check({when, " s_ready"}, bus.s_ready, rdy_ok && (q.size() < 2));
      check({when, " wlevel"}, bus.wlevel, exp_level);
      check({when, " almost_full"}, bus.almost_full, exp_level >= AF);
   endtask

   // One clock: inputs are set at the negedge before this call; outputs checked at the next negedge
   task automatic cycle(input string when, output bit fired);
      bit            cons;
      int            nl;
      logic [DW-1:0] sd;
      logic [DW-1:0] wd;
      fired = bus.s_valid && bus.s_ready;
      cons  = bus.w_en && !bus.full;
      sd    = bus.s_data;
      wd    = bus.wdata;
      nl    = ref_level(int'(bus.b_wptr), int'(bus.g_rptr_sync));
      @(posedge wclk);
      if (wrst_n) begin
         if (cons) begin
            q.delete(0);
            wr_log.push_back(wd);
            $display("[%0t] write  0x%02h", $time, wd);
         end
         if (fired) begin
            q.push_back(sd);
            $display("[%0t] accept 0x%02h", $time, sd);
         end
         exp_level = nl;
         rdy_ok    = 1'b1;
      end
      @(negedge wclk);
      check_state(when);
   endtask

   initial begin
      bit            f;
      int            nxt;
      int            guard;
      int            rb;
      int            lv;
      logic [DW-1:0] exp_seq[$];

      wrst_n          = 1'b0;
      bus.s_valid     = 1'b0;
      bus.s_data      = '0;
      bus.full        = 1'b0;
      bus.b_wptr      = 4'd3;
      bus.g_rptr_sync = '0;
      rdy_ok          = 1'b0;
      exp_level       = 0;

      // reset and idle
      repeat (2) @(negedge wclk);
      check("rst s_ready", bus.s_ready, 0);
      check("rst w_en", bus.w_en, 0);
      check("rst wdata", bus.wdata, 0);
      check("rst wlevel", bus.wlevel, 0);
      check("rst almost_full", bus.almost_full, 0);
      wrst_n     = 1'b1;
      bus.b_wptr = '0;
      #1;
      check("release s_ready before edge", bus.s_ready, 0);
      cycle("idle", f);
      check("release s_ready after edge", bus.s_ready, 1);
      check("idle w_en", bus.w_en, 0);

      // streaming 0x01..0x08
      wr_log.delete();
      nxt = 1;
      guard = 0;
      bus.s_valid = 1'b1;
      while (wr_log.size() < 8 && guard < 40) begin
         bus.s_valid = (nxt <= 8);
         bus.s_data  = nxt[DW-1:0];
         cycle("stream", f);
         if (f) nxt++;
         if (guard == 0) check("stream first w_en", bus.w_en, 1);
         if (nxt <= 8) check("stream s_ready", bus.s_ready, 1);
         guard++;
      end
      check("stream count", wr_log.size(), 8);
      for (int i = 0; i < 8 && i < wr_log.size(); i++) check("stream order", wr_log[i], i + 1);
      bus.s_valid = 1'b0;
      cycle("stream idle", f);

      // full stall with skid fill
      wr_log.delete();
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h10;
      cycle("stall load", f);
      check("stall wdata 10", bus.wdata, 8'h10);
      bus.full   = 1'b1;
      bus.s_data = 8'h11;
      cycle("stall skid", f);
      check("stall hold wdata", bus.wdata, 8'h10);
      check("stall s_ready low", bus.s_ready, 0);
      bus.s_data = 8'h12;
      repeat (2) cycle("stall wait", f);
      check("stall still w_en", bus.w_en, 1);
      check("stall still wdata", bus.wdata, 8'h10);
      bus.full = 1'b0;
      guard = 0;
      while (wr_log.size() < 3 && guard < 20) begin
         cycle("stall drain", f);
         if (f) bus.s_valid = 1'b0;
         guard++;
      end
      bus.s_valid = 1'b0;
      exp_seq = '{8'h10, 8'h11, 8'h12};
      check("stall drain count", wr_log.size(), 3);
      for (int i = 0; i < 3 && i < wr_log.size(); i++) check("stall drain order", wr_log[i], exp_seq[i]);
      cycle("stall idle", f);

      // level and almost_full
      bus.b_wptr      = 4'd5;
      bus.g_rptr_sync = 4'b0000;
      cycle("level5", f);
      check("level 5", bus.wlevel, 5);
      check("level 5 af", bus.almost_full, 0);
      bus.b_wptr = 4'd6;
      cycle("level6", f);
      check("level 6", bus.wlevel, 6);
      check("level 6 af", bus.almost_full, 1);
      bus.b_wptr      = 4'b0010;
      bus.g_rptr_sync = 4'b1010;
      cycle("wrap6", f);
      check("wrap level 6", bus.wlevel, 6);
      bus.b_wptr      = 4'b1000;
      bus.g_rptr_sync = 4'b0000;
      cycle("wrap8", f);
      check("wrap level 8", bus.wlevel, 8);
      check("wrap level 8 af", bus.almost_full, 1);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         bus.s_valid     = ($urandom_range(0, 3) != 0);
         bus.s_data      = DW'($urandom);
         bus.full        = ($urandom_range(0, 3) == 0);
         rb              = $urandom_range(0, PMASK);
         lv              = $urandom_range(0, 1 << PW);
         bus.b_wptr      = 4'((rb + lv) & PMASK);
         bus.g_rptr_sync = 4'(bin2gray(rb));
         cycle("rand", f);
      end
      bus.s_valid = 1'b0;
      bus.full    = 1'b0;
      repeat (4) cycle("rand drain", f);
      check("rand drained w_en", bus.w_en, 0);

      // asynchronous reset with both slots occupied
      bus.full        = 1'b1;
      bus.s_valid     = 1'b1;
      bus.s_data      = 8'hA0;
      bus.b_wptr      = 4'd7;
      bus.g_rptr_sync = 4'd0;
      cycle("arst fill0", f);
      bus.s_data = 8'hA1;
      cycle("arst fill1", f);
      cycle("arst fill2", f);
      check("arst pre w_en", bus.w_en, 1);
      check("arst pre s_ready", bus.s_ready, 0);
      check("arst pre wlevel", bus.wlevel, 7);
      #2;
      wrst_n = 1'b0;
      #1;
      check("arst w_en", bus.w_en, 0);
      check("arst s_ready", bus.s_ready, 0);
      check("arst wlevel", bus.wlevel, 0);
      check("arst almost_full", bus.almost_full, 0);
      q.delete();
      rdy_ok    = 1'b0;
      exp_level = 0;
      @(negedge wclk);
      check_state("arst held");
      wrst_n          = 1'b1;
      bus.full        = 1'b0;
      bus.s_valid     = 1'b0;
      bus.b_wptr      = '0;
      cycle("arst release", f);
      check("arst release s_ready", bus.s_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
